safety_lock_top: RTL and testbench

- Top level of the safety-lock block. A 4-bit parallel code entry is accepted over a valid/ready handshake and serialized MSB-first, one bit per clock.
- A serial comparator FSM checks the bit stream against a fixed unlock code.
- After the 4th bit, a one-cycle result is issued: output_valid=1, with out=1 on match and out=0 on mismatch.

---
 rtl/safety_lock_pkg.sv | 26 ++
 rtl/safety_lock_piso_4.sv | 38 +++
 rtl/safety_lock_top.sv | 88 ++++++++
 tb/tb_safety_lock_top.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/safety_lock_pkg.sv
// Shared types and constants for the safety-lock block.
package safety_lock_pkg;

    localparam int DATA_W = 4;
    localparam logic [DATA_W-1:0] DEFAULT_CODE = 4'b1011;

    // Comparator states; C3..C0 name the code bit expected next.
    typedef enum logic [2:0] {
        IDLE,
        C3,
        C2,
        C1,
        C0
    } cmp_state_e;

    // Code bit index compared while in a given state.
    function automatic logic [1:0] state_index(input cmp_state_e s);
        case (s)
            C3:      return 2'd3;
            C2:      return 2'd2;
            C1:      return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/safety_lock_piso_4.sv
// 4-bit parallel-in / serial-out shifter, MSB first, with a valid/ready
// entry handshake. Ready only while no bits remain in flight.
module piso_4
    import safety_lock_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              par_valid,
    input  logic [DATA_W-1:0] par_data,
    output logic              par_ready,
    output logic              serial_valid,
    output logic              serial_bit
);

    logic [DATA_W-1:0] shreg;
    logic [2:0]        count;

    assign par_ready    = (count == 3'd0);
    assign serial_valid = (count != 3'd0);
    assign serial_bit   = shreg[DATA_W-1];

    // Load on handshake, otherwise shift one bit out per clock.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
            count <= 3'd0;
        end else if (par_valid && par_ready) begin
            shreg <= par_data;
            count <= 3'd4;
        end else if (count != 3'd0) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            count <= count - 3'd1;
        end
    end

endmodule

// File: rtl/safety_lock_top.sv
// Safety lock: serializes a 4-bit code entry and compares it bit by bit
// against a fixed unlock code, issuing a one-cycle result pulse.
module safety_lock_top
    import safety_lock_pkg::*;
#(
    parameter logic [DATA_W-1:0] CODE = DEFAULT_CODE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              par_valid,
    input  logic [DATA_W-1:0] par_data,
    output logic              par_ready,
    output logic              output_valid,
    output logic              out
);

    logic       serial_valid;
    logic       serial_bit;
    logic       accept;

    cmp_state_e state_q, state_d;
    logic       match_q, match_d;
    logic       out_valid_d, out_d;

    piso_4 u_piso (
        .clk          (clk),
        .rstn         (rstn),
        .par_valid    (par_valid),
        .par_data     (par_data),
        .par_ready    (par_ready),
        .serial_valid (serial_valid),
        .serial_bit   (serial_bit)
    );

    assign accept = par_valid && par_ready;

    // Comparator state, running match flag and registered result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            match_q      <= 1'b0;
            output_valid <= 1'b0;
            out          <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            output_valid <= out_valid_d;
            out          <= out_d;
        end
    end

    // Next-state, match tracking and result decode; every bit is consumed
    // even after a mismatch so each entry takes the same time.
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        out_valid_d = 1'b0;
        out_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = C3;
                    match_d = 1'b1;
                end
            end
            default: begin
                if (serial_valid) begin
                    if (serial_bit != CODE[state_index(state_q)]) begin
                        match_d = 1'b0;
                    end
                    case (state_q)
                        C3:      state_d = C2;
                        C2:      state_d = C1;
                        C1:      state_d = C0;
                        default: begin
                            state_d     = IDLE;
                            out_valid_d = 1'b1;
                            out_d       = match_d;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_safety_lock_top.sv
// Self-checking bench for safety_lock_top: directed entries, scoreboard of
// expected results (value and arrival cycle), monitor on the falling edge.
module tb_safety_lock_top;

    localparam logic [3:0] CODE = 4'b1011;

    logic       clk = 1'b0;
    logic       rstn;
    logic       par_valid;
    logic [3:0] par_data;
    logic       par_ready;
    logic       output_valid;
    logic       out;

    typedef struct {
        logic exp_out;
        int   exp_cycle;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   pulses = 0;
    int   tests  = 0;
    int   fails  = 0;

    safety_lock_top dut (
        .clk          (clk),
        .rstn         (rstn),
        .par_valid    (par_valid),
        .par_data     (par_data),
        .par_ready    (par_ready),
        .output_valid (output_valid),
        .out          (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Monitor: compare each result pulse against the scoreboard head.
    always @(negedge clk) begin
        if (output_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_out", 32'(out), 32'(e.exp_out));
                check("result_cycle", cycle, e.exp_cycle);
            end
        end else begin
            check("out_zero_when_idle", 32'(out), 32'd0);
        end
    end

    // Present an entry, wait (bounded) for acceptance, record the expected result.
    task automatic send(input logic [3:0] data, input bit hold, output int acc_cycle);
        int waited = 0;
        acc_cycle = -1;
        @(negedge clk);
        par_data  = data;
        par_valid = 1'b1;
        while (par_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(waited < 20), 32'd1);
        if (par_ready === 1'b1) begin
            acc_cycle = cycle + 1;
            sb.push_back('{exp_out: (data == CODE), exp_cycle: cycle + 5});
        end
        @(posedge clk);
        #1;
        if (!hold) par_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int a1, a2, p0;
        rstn      = 1'b0;
        par_valid = 1'b0;
        par_data  = 4'b0000;

        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 32'(par_ready), 32'd1);
            check("rst_ovalid", 32'(output_valid), 32'd0);
            check("rst_out", 32'(out), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(par_ready), 32'd1);
        check("post_rst_ovalid", 32'(output_valid), 32'd0);

        // Mismatch 1010: ready low for 4 cycles, result on the 5th.
        send(4'b1010, 1'b0, a1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_ready_low", 32'(par_ready), 32'd0);
        end
        @(negedge clk);
        check("ready_back_with_result", 32'(par_ready), 32'd1);
        check("ovalid_with_ready", 32'(output_valid), 32'd1);
        drain();

        // Mismatch then match.
        send(4'b1101, 1'b0, a1);
        send(4'b1011, 1'b0, a1);
        drain();

        // Back-to-back with par_valid held high.
        send(4'b1011, 1'b1, a1);
        send(4'b0011, 1'b0, a2);
        check("b2b_spacing", a2 - a1, 32'd5);
        drain();

        // Entry while busy is ignored.
        p0 = pulses;
        send(4'b1011, 1'b0, a1);
        @(negedge clk);
        par_data  = 4'b0000;
        par_valid = 1'b1;
        @(negedge clk);
        par_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("busy_entry_ignored", pulses - p0, 32'd1);

        // Reset in mid-entry aborts it.
        p0 = pulses;
        send(4'b1011, 1'b0, a1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_ready", 32'(par_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_pulse", pulses - p0, 32'd0);
        check("midrst_ready_after", 32'(par_ready), 32'd1);
        send(4'b1011, 1'b0, a1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
